// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared command encodings and default sizes for the operand stack
package stack_pkg;

    localparam int STK_WIDTH_DEF = 16;
    localparam int STK_DEPTH_DEF = 16;

    // Encodings 3'b110/3'b111 are deliberately absent and decode as NOP
    typedef enum logic [2:0] {
        NOP    = 3'b000,
        PUSH   = 3'b001,
        POP    = 3'b010,
        REDUCE = 3'b011,
        DUP    = 3'b100,
        SWAP   = 3'b101
    } stk_op_t;

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH register array, two async read ports, two sync write ports
module stack_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we_a,
    input  logic [AW-1:0]    i_waddr_a,
    input  logic [WIDTH-1:0] i_wdata_a,
    input  logic             i_we_b,
    input  logic [AW-1:0]    i_waddr_b,
    input  logic [WIDTH-1:0] i_wdata_b,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Port B is only used by SWAP, whose two addresses never coincide
    always_ff @(posedge clk) begin
        if (i_we_a) r_mem[i_waddr_a] <= i_wdata_a;
        if (i_we_b) r_mem[i_waddr_b] <= i_wdata_b;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - LIFO operand stack presenting NOS/TOS to the ALU and committing results
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STK_WIDTH_DEF,
    parameter int DEPTH = STK_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       stk_op,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             err_clr,
    output logic [WIDTH-1:0] operand1,
    output logic [WIDTH-1:0] operand2,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full, w_empty, w_lt2;
    logic [AW-1:0]    w_push_idx, w_tos_idx, w_nos_idx;
    logic [WIDTH-1:0] w_tos_raw, w_nos_raw;
    logic             w_we_a, w_we_b;
    logic [AW-1:0]    w_waddr_a, w_waddr_b;
    logic [WIDTH-1:0] w_wdata_a, w_wdata_b;
    logic             w_inc, w_dec, w_ovf, w_unf;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_lt2      = (r_count < CNT_W'(2));
    assign w_push_idx = AW'(r_count);
    assign w_tos_idx  = AW'(r_count - CNT_W'(1));
    assign w_nos_idx  = AW'(r_count - CNT_W'(2));

    always_comb begin
        w_we_a    = 1'b0;
        w_we_b    = 1'b0;
        w_waddr_a = w_push_idx;
        w_waddr_b = w_nos_idx;
        w_wdata_a = push_data;
        w_wdata_b = w_tos_raw;
        w_inc     = 1'b0;
        w_dec     = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        case (stk_op)
            PUSH: begin
                if (w_full) w_ovf = 1'b1;
                else begin
                    w_we_a = 1'b1;
                    w_inc  = 1'b1;
                end
            end
            POP: begin
                if (w_empty) w_unf = 1'b1;
                else         w_dec = 1'b1;
            end
            REDUCE: begin
                if (w_lt2) w_unf = 1'b1;
                else begin
                    w_we_a    = 1'b1;
                    w_waddr_a = w_nos_idx;
                    w_wdata_a = alu_result;
                    w_dec     = 1'b1;
                end
            end
            DUP: begin
                if (w_empty)     w_unf = 1'b1;
                else if (w_full) w_ovf = 1'b1;
                else begin
                    w_we_a    = 1'b1;
                    w_wdata_a = w_tos_raw;
                    w_inc     = 1'b1;
                end
            end
            SWAP: begin
                if (w_lt2) w_unf = 1'b1;
                else begin
                    w_we_a    = 1'b1;
                    w_waddr_a = w_tos_idx;
                    w_wdata_a = w_nos_raw;
                    w_we_b    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gate writes with reset so a command pending under reset leaves storage untouched
    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .i_we_a    (w_we_a & rst_n),
        .i_waddr_a (w_waddr_a),
        .i_wdata_a (w_wdata_a),
        .i_we_b    (w_we_b & rst_n),
        .i_waddr_b (w_waddr_b),
        .i_wdata_b (w_wdata_b),
        .i_raddr_a (w_tos_idx),
        .o_rdata_a (w_tos_raw),
        .i_raddr_b (w_nos_idx),
        .o_rdata_b (w_nos_raw)
    );

    // A new error in the same cycle as err_clr wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_inc)      r_count <= r_count + CNT_W'(1);
            else if (w_dec) r_count <= r_count - CNT_W'(1);
            r_overflow  <= (r_overflow  & ~err_clr) | w_ovf;
            r_underflow <= (r_underflow & ~err_clr) | w_unf;
        end
    end

    assign operand2  = w_empty ? '0 : w_tos_raw;
    assign operand1  = w_lt2   ? '0 : w_nos_raw;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - self-checking bench for operand_stack against a queue-based stack model
module tb_operand_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] C_NOP = 3'd0, C_PUSH = 3'd1, C_POP = 3'd2,
                           C_RED = 3'd3, C_DUP = 3'd4, C_SWAP = 3'd5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       stk_op = 3'd0;
    logic [WIDTH-1:0] push_data = '0;
    logic [WIDTH-1:0] alu_result = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] operand1, operand2;
    logic [CNT_W-1:0] count;
    logic             full, empty, overflow, underflow;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_stk[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    always #5 clk = ~clk;

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stk_op     (stk_op),
        .push_data  (push_data),
        .alu_result (alu_result),
        .err_clr    (err_clr),
        .operand1   (operand1),
        .operand2   (operand2),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    function automatic logic [WIDTH-1:0] exp_tos();
        return (m_stk.size() >= 1) ? m_stk[m_stk.size()-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_nos();
        return (m_stk.size() >= 2) ? m_stk[m_stk.size()-2] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] alu_model(input logic [2:0] code,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (code)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(count),     32'(m_stk.size()));
        check({tag, ".operand1"},  32'(operand1),  32'(exp_nos()));
        check({tag, ".operand2"},  32'(operand2),  32'(exp_tos()));
        check({tag, ".full"},      32'(full),      32'(m_stk.size() == DEPTH));
        check({tag, ".empty"},     32'(empty),     32'(m_stk.size() == 0));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_step(input logic [2:0] op, input logic [WIDTH-1:0] d,
                              input logic [WIDTH-1:0] alu, input logic clr);
        logic [WIDTH-1:0] t, n;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (op)
            C_PUSH: if (m_stk.size() == DEPTH) m_ovf = 1'b1; else m_stk.push_back(d);
            C_POP:  if (m_stk.size() == 0) m_unf = 1'b1; else void'(m_stk.pop_back());
            C_RED: begin
                if (m_stk.size() < 2) m_unf = 1'b1;
                else begin
                    void'(m_stk.pop_back());
                    m_stk[m_stk.size()-1] = alu;
                end
            end
            C_DUP: begin
                if (m_stk.size() == 0) m_unf = 1'b1;
                else if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                else m_stk.push_back(m_stk[m_stk.size()-1]);
            end
            C_SWAP: begin
                if (m_stk.size() < 2) m_unf = 1'b1;
                else begin
                    t = m_stk.pop_back();
                    n = m_stk.pop_back();
                    m_stk.push_back(t);
                    m_stk.push_back(n);
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] alu, input logic clr);
        @(negedge clk);
        stk_op     = op;
        push_data  = d;
        alu_result = alu;
        err_clr    = clr;
        model_step(op, d, alu, clr);
        @(posedge clk);
        #1;
        stk_op  = C_NOP;
        err_clr = 1'b0;
    endtask

    task automatic reduce_with(input logic [2:0] code, input logic clr);
        step(C_RED, $urandom, alu_model(code, exp_nos(), exp_tos()), clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        do_reset();
        check_all("reset");

        step(C_PUSH, 16'h0005, 16'h0, 1'b0);
        step(C_PUSH, 16'h0003, 16'h0, 1'b0);
        check("basic.count", 32'(count), 32'd2);
        check("basic.op1", 32'(operand1), 32'h0005);
        check("basic.op2", 32'(operand2), 32'h0003);
        step(C_RED, 16'h0, 16'h0002, 1'b0);
        check("reduce.op2", 32'(operand2), 32'h0002);
        check("reduce.op1", 32'(operand1), 32'h0000);
        check_all("reduce");

        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(C_PUSH, 16'(i), 16'h0, 1'b0);
        check("fill.full", 32'(full), 32'd1);
        check("fill.op2", 32'(operand2), 32'h0010);
        step(C_PUSH, 16'hBEEF, 16'h0, 1'b0);
        check("ovf.count", 32'(count), 32'd16);
        check("ovf.flag", 32'(overflow), 32'd1);
        check_all("ovf");
        step(C_DUP, 16'h0, 16'h0, 1'b0);
        check_all("dup_full");
        step(C_POP, 16'h0, 16'h0, 1'b1);
        check_all("pop_clr");

        do_reset();
        step(C_POP, 16'h0, 16'h0, 1'b0);
        step(C_RED, 16'h0, 16'h0, 1'b0);
        check("unf.flag", 32'(underflow), 32'd1);
        step(C_POP, 16'h0, 16'h0, 1'b1);
        check("unf.set_beats_clr", 32'(underflow), 32'd1);
        step(C_NOP, 16'h0, 16'h0, 1'b1);
        check("unf.cleared", 32'(underflow), 32'd0);
        step(C_PUSH, 16'h0007, 16'h0, 1'b0);
        step(C_RED, 16'h0, 16'h1234, 1'b0);
        check("unf.reduce_cnt1", 32'(underflow), 32'd1);
        check_all("unf");

        do_reset();
        step(C_PUSH, 16'h000F, 16'h0, 1'b0);
        step(C_PUSH, 16'h003C, 16'h0, 1'b0);
        step(C_SWAP, 16'h0, 16'h0, 1'b0);
        check("swap.op1", 32'(operand1), 32'h003C);
        check("swap.op2", 32'(operand2), 32'h000F);
        step(C_DUP, 16'h0, 16'h0, 1'b0);
        check("dup.count", 32'(count), 32'd3);
        check("dup.op1", 32'(operand1), 32'h000F);
        check_all("dup");

        step(C_PUSH, 16'h1111, 16'h0, 1'b0);
        step(C_PUSH, 16'h2222, 16'h0, 1'b0);
        check("pre_rst.count", 32'(count), 32'd5);
        @(negedge clk);
        #2;
        stk_op    = C_PUSH;
        push_data = 16'hDEAD;
        rst_n     = 1'b0;
        #1;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        stk_op = C_NOP;
        rst_n  = 1'b1;

        step(C_PUSH, 16'h000F, 16'h0, 1'b0);
        step(C_PUSH, 16'h003C, 16'h0, 1'b0);
        reduce_with(3'b010, 1'b0);
        check("alu_and", 32'(operand2), 32'h000C);
        step(C_PUSH, 16'h003C, 16'h0, 1'b0);
        step(C_SWAP, 16'h0, 16'h0, 1'b0);
        step(C_POP, 16'h0, 16'h0, 1'b0);
        step(C_PUSH, 16'h000F, 16'h0, 1'b0);
        step(C_PUSH, 16'h003C, 16'h0, 1'b0);
        reduce_with(3'b011, 1'b0);
        check("alu_or", 32'(operand2), 32'h003F);
        check_all("alu");

        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            logic       clr;
            op  = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) op = C_PUSH;
            if (op == C_RED) reduce_with(3'($urandom_range(0, 7)), clr);
            else step(op, 16'($urandom), 16'($urandom), clr);
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
